// File: rtl/palette_write_sched.sv
// Palette RAM write-port scheduler. It queues CPU palette writes in a FIFO and commits
// them only during blanking, so that a palette update never tears an active scanline.
module palette_write_sched #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_pix,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_index,
  input  logic [23:0]              wr_rgb,
  input  logic                     de_next,
  input  logic                     vblank_next,
  input  logic                     mode,
  output logic                     pal_we,
  output logic [7:0]               pal_addr,
  output logic [23:0]              pal_wdata,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [31:0]   mem_q [DEPTH];

  logic          we_q, we_d;
  logic [7:0]    addr_q, addr_d;
  logic [23:0]   wdata_q, wdata_d;

  logic          win;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  // The window is built from the _next flags, so a write registered now lands in blanking.
  assign win      = mode ? vblank_next : !de_next;
  assign wr_ready = (count_q != CW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == DRAIN) && win && (count_q != '0);
  assign head     = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    we_d    = pop;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (pop) begin
      addr_d  = head[31:24];
      wdata_d = head[23:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (push) begin
          state_d = win ? DRAIN : HOLD;
        end
      end
      HOLD: begin
        if (win) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_d == '0) begin
          state_d = IDLE;
        end else if (!win) begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_pix) begin
    if (push) begin
      mem_q[wptr_q] <= {wr_index, wr_rgb};
    end
  end

  assign pal_we    = we_q;
  assign pal_addr  = addr_q;
  assign pal_wdata = wdata_q;
  assign pending   = count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_palette_write_sched.sv
// Bench for palette_write_sched: directed scenarios followed by randomized traffic,
// checked on every cycle against a queue-based model of the commit rules.
module tb_palette_write_sched;

  localparam int unsigned DEPTH = 4;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_index = '0;
  logic [23:0] wr_rgb = '0;
  logic        de_next = 1'b1;
  logic        vblank_next = 1'b0;
  logic        mode = 1'b0;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [2:0]  pending;
  logic        busy;

  palette_write_sched #(.DEPTH(DEPTH)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_index(wr_index), .wr_rgb(wr_rgb), .de_next(de_next), .vblank_next(vblank_next),
    .mode(mode), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .pending(pending), .busy(busy)
  );

  always #5 clk_pix = ~clk_pix;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue. An entry commits in a cycle whose window is open when the
  // window was also open in the previous cycle with data left queued after it.
  logic [31:0] q[$];
  logic [7:0]  obs[$];
  logic        prev_ok = 1'b0;
  logic        exp_we = 1'b0;
  logic [7:0]  exp_addr = '0;
  logic [23:0] exp_data = '0;

  always @(posedge clk_pix) begin
    logic        m_win, m_push, m_pop;
    logic [31:0] e;
    if (!rst_n) begin
      q.delete();
      obs.delete();
      prev_ok  = 1'b0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      m_win  = mode ? vblank_next : !de_next;
      m_push = wr_valid && (q.size() != DEPTH);
      m_pop  = prev_ok && m_win && (q.size() != 0);
      exp_we = m_pop;
      if (m_pop) begin
        e        = q.pop_front();
        exp_addr = e[31:24];
        exp_data = e[23:0];
      end
      if (m_push) q.push_back({wr_index, wr_rgb});
      prev_ok = m_win && (q.size() != 0);
    end
    #1;
    check("m_we", pal_we, exp_we);
    check("m_addr", pal_addr, exp_addr);
    check("m_data", pal_wdata, exp_data);
    check("m_pending", pending, q.size());
    check("m_busy", busy, q.size() != 0);
    check("m_ready", wr_ready, q.size() != DEPTH);
    if (pal_we && rst_n) obs.push_back(pal_addr);
  end

  task automatic cyc();
    @(negedge clk_pix);
  endtask

  task automatic drain(input string name);
    de_next = 1'b0;
    mode    = 1'b0;
    for (int i = 0; i < 50 && pending != 0; i++) cyc();
    cyc();
    check(name, pending, 0);
    de_next = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(); cyc();
    check("rst_we", pal_we, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_addr", pal_addr, 0);
    rst_n = 1'b1;

    // idle with window closed and open
    for (int i = 0; i < 100; i++) begin
      de_next = (i >= 50) ? 1'b0 : 1'b1;
      cyc();
      check("idle_we", pal_we, 0);
      check("idle_busy", busy, 0);
    end

    // single write, window open: 2-cycle latency
    de_next = 1'b0; mode = 1'b0;
    wr_valid = 1'b1; wr_index = 8'h05; wr_rgb = 24'h123456;
    cyc();
    wr_valid = 1'b0;
    check("t2_we_n1", pal_we, 0);
    check("t2_pend_n1", pending, 1);
    cyc();
    check("t2_we_n2", pal_we, 1);
    check("t2_addr", pal_addr, 8'h05);
    check("t2_data", pal_wdata, 24'h123456);
    cyc();
    check("t2_we_after", pal_we, 0);
    check("t2_busy_after", busy, 0);

    // fill during active video, then a short window
    de_next = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_index = 8'h10 + 8'(i); wr_rgb = 24'($urandom);
      cyc();
    end
    wr_valid = 1'b0;
    check("t3_ready", wr_ready, 0);
    check("t3_pending", pending, 4);
    check("t3_busy", busy, 1);
    cyc(); cyc(); cyc();
    check("t3_hold_we", pal_we, 0);
    obs.delete();
    de_next = 1'b0;
    cyc();
    check("t3_we_a", pal_we, 0);
    cyc();
    check("t3_we_b", pal_we, 1);
    check("t3_addr_b", pal_addr, 8'h10);
    check("t3_ready_b", wr_ready, 1);
    cyc();
    check("t3_addr_c", pal_addr, 8'h11);
    de_next = 1'b1;
    cyc();
    check("t3_we_d", pal_we, 0);
    check("t3_pending_d", pending, 2);
    check("t3_nwrites", obs.size(), 2);
    drain("t3_drain");

    // vblank-only mode
    mode = 1'b1; vblank_next = 1'b0; de_next = 1'b0;
    wr_valid = 1'b1; wr_index = 8'h44; wr_rgb = 24'hABCDEF;
    cyc();
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t4_no_we", pal_we, 0);
    end
    check("t4_pending", pending, 1);
    vblank_next = 1'b1;
    cyc();
    check("t4_we_v1", pal_we, 0);
    cyc();
    check("t4_we_v2", pal_we, 1);
    check("t4_addr", pal_addr, 8'h44);
    check("t4_data", pal_wdata, 24'hABCDEF);
    vblank_next = 1'b0; mode = 1'b0; de_next = 1'b1;
    cyc();

    // backpressure while full
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_index = 8'h30 + 8'(i); wr_rgb = 24'($urandom);
      cyc();
    end
    wr_index = 8'h20; wr_rgb = 24'h202020;
    cyc(); cyc();
    check("t5_full", wr_ready, 0);
    check("t5_pending", pending, 4);
    de_next = 1'b0;
    for (int i = 0; i < 20 && !wr_ready; i++) cyc();
    check("t5_ready", wr_ready, 1);
    check("t5_pending_free", pending, 3);
    cyc();
    wr_valid = 1'b0;
    drain("t5_drain");
    check("t5_nwrites", obs.size(), 5);
    if (obs.size() == 5) begin
      for (int i = 0; i < 4; i++) check("t5_order", obs[i], 8'h30 + 8'(i));
      check("t5_last", obs[4], 8'h20);
    end

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_index = 8'h50 + 8'(i); wr_rgb = 24'($urandom);
      cyc();
    end
    wr_valid = 1'b0;
    de_next = 1'b0;
    cyc(); cyc();
    check("t6_we_pre", pal_we, 1);
    check("t6_pend_pre", pending, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_we_rst", pal_we, 0);
    check("t6_pend_rst", pending, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_ready_rst", wr_ready, 1);
    cyc(); cyc(); cyc();
    rst_n = 1'b1;
    obs.delete();
    for (int i = 0; i < 20; i++) cyc();
    check("t6_no_stale", obs.size(), 0);
    check("t6_pending", pending, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      wr_valid    = ($urandom_range(0, 1) == 1);
      wr_index    = 8'($urandom);
      wr_rgb      = 24'($urandom);
      de_next     = ($urandom_range(0, 9) < 7);
      vblank_next = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end
    wr_valid = 1'b0;
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
